// File: rtl/pong_pkg.sv
// pong_pkg: shared definitions for the pong score keeper.
//   - state_t     : controller states (IDLE/SERVE/PLAY/OVER)
//   - SCORE_W     : width of each player's score
//   - result field positions for the packed 32-bit result word
//   - sat_inc()   : saturating score increment
package pong_pkg;

  localparam int SCORE_W    = 15;

  localparam int SCORE1_MSB = 31;
  localparam int SCORE1_LSB = 17;
  localparam int DIRTY1     = 16;
  localparam int SCORE2_MSB = 15;
  localparam int SCORE2_LSB = 1;
  localparam int DIRTY2     = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  // Increment a score but never past cap (scores must never wrap).
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                 input logic [SCORE_W-1:0] cap);
    return (v >= cap) ? cap : v + 1'b1;
  endfunction

endpackage

// File: rtl/pong_score_keeper_if.sv
// pong_score_keeper_if: groups the host/ball-engine side signals of the score keeper.
//   Inputs to the keeper : clk_en (read strobe), enablePong, i_vs, goal_p1, goal_p2, clr_scores
//   Outputs of the keeper: result[31:0], serve_hold, match_over, winner, dbg_state
// Handshake: there is no valid/ready pair; clk_en is a one-cycle read strobe.
// The host samples result in the strobe cycle and the dirty bits drop the
// following cycle unless a new point or a clear lands in that same cycle.
// modport master: host/stimulus side.  modport slave: the score keeper.
interface pong_score_keeper_if;
  import pong_pkg::*;

  logic        clk_en;
  logic        enablePong;
  logic        i_vs;
  logic        goal_p1;
  logic        goal_p2;
  logic        clr_scores;
  logic [31:0] result;
  logic        serve_hold;
  logic        match_over;
  logic        winner;
  state_t      dbg_state;

  modport master (
    output clk_en, enablePong, i_vs, goal_p1, goal_p2, clr_scores,
    input  result, serve_hold, match_over, winner, dbg_state
  );

  modport slave (
    input  clk_en, enablePong, i_vs, goal_p1, goal_p2, clr_scores,
    output result, serve_hold, match_over, winner, dbg_state
  );

endinterface

// File: rtl/pong_edge_detect.sv
// pong_edge_detect: single-edge pulse detector against a registered copy of
// the input.
//   clk_in   in  clock
//   i_rst_n  in  async active-low reset (previous value resets to 0)
//   i_sig    in  level to watch
//   o_pulse  out 1-cycle pulse on rising edge (EDGE_FALL=0) or falling edge (EDGE_FALL=1)
// A previous value of 0 at reset means a high level at reset release is seen
// as a rising edge, never as a falling edge.
module pong_edge_detect #(
  parameter bit EDGE_FALL = 1'b0
) (
  input  logic clk_in,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_pulse
);

  logic r_prev;

  always_ff @(posedge clk_in or negedge i_rst_n) begin
    if (!i_rst_n) r_prev <= 1'b0;
    else          r_prev <= i_sig;
  end

  assign o_pulse = EDGE_FALL ? (~i_sig & r_prev) : (i_sig & ~r_prev);

endmodule

// File: rtl/pong_score_keeper.sv
// pong_score_keeper: score/serve controller downstream of the ball engine.
// Counts goals per player, holds the ball for SERVE_FRAMES frames between
// points, decides the winner and packs scores plus dirty bits into result.
//   clk_in   in  clock, all logic on posedge
//   i_rst_n  in  async active-low reset
//   bus      slave modport of pong_score_keeper_if (see interface header)
// Parameters: MAX_SCORE (1..32767), SERVE_FRAMES (1..255).
// Build option: WIN_BY_TWO_EN -- when defined the scorer must reach
// MAX_SCORE and lead by two; scores then saturate at 32767.
module pong_score_keeper
  import pong_pkg::*;
#(
  parameter int MAX_SCORE    = 15,
  parameter int SERVE_FRAMES = 60
) (
  input logic             clk_in,
  input logic             i_rst_n,
  pong_score_keeper_if.slave bus
);

  localparam logic [SCORE_W-1:0] MAX_S      = SCORE_W'(MAX_SCORE);
  localparam logic [7:0]         LAST_FRAME = 8'(SERVE_FRAMES - 1);
`ifdef WIN_BY_TWO_EN
  localparam logic [SCORE_W-1:0] CAP        = {SCORE_W{1'b1}};
`else
  localparam logic [SCORE_W-1:0] CAP        = MAX_S;
`endif

  state_t             r_state;
  logic [7:0]         r_frame_cnt;
  logic [SCORE_W-1:0] r_score1;
  logic [SCORE_W-1:0] r_score2;
  logic               r_dirty1;
  logic               r_dirty2;
  logic               r_serve_hold;
  logic               r_match_over;
  logic               r_winner;

  logic               w_goal1;
  logic               w_goal2;
  logic               w_vs_fall;
  logic [SCORE_W-1:0] w_new1;
  logic [SCORE_W-1:0] w_new2;
  logic               w_win1;
  logic               w_win2;

  pong_edge_detect #(.EDGE_FALL(1'b0)) u_goal1 (
    .clk_in (clk_in), .i_rst_n(i_rst_n), .i_sig(bus.goal_p1), .o_pulse(w_goal1)
  );
  pong_edge_detect #(.EDGE_FALL(1'b0)) u_goal2 (
    .clk_in (clk_in), .i_rst_n(i_rst_n), .i_sig(bus.goal_p2), .o_pulse(w_goal2)
  );
  // VGA vsync is active low: the falling edge marks the start of a frame.
  pong_edge_detect #(.EDGE_FALL(1'b1)) u_vs (
    .clk_in (clk_in), .i_rst_n(i_rst_n), .i_sig(bus.i_vs), .o_pulse(w_vs_fall)
  );

  assign w_new1 = sat_inc(r_score1, CAP);
  assign w_new2 = sat_inc(r_score2, CAP);

`ifdef WIN_BY_TWO_EN
  // 16-bit compare so score+2 cannot overflow near 32767.
  assign w_win1 = (w_new1 >= MAX_S) && ({1'b0, w_new1} >= ({1'b0, r_score2} + 16'd2));
  assign w_win2 = (w_new2 >= MAX_S) && ({1'b0, w_new2} >= ({1'b0, r_score1} + 16'd2));
`else
  assign w_win1 = (w_new1 == MAX_S);
  assign w_win2 = (w_new2 == MAX_S);
`endif

  always_ff @(posedge clk_in or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_frame_cnt  <= 8'd0;
      r_score1     <= '0;
      r_score2     <= '0;
      r_dirty1     <= 1'b0;
      r_dirty2     <= 1'b0;
      r_serve_hold <= 1'b1;
      r_match_over <= 1'b0;
      r_winner     <= 1'b0;
    end else begin
      // A host read clears the dirty bits; later assignments in this cycle
      // (a point or a clear) override, so a new event wins over the read.
      if (bus.clk_en) begin
        r_dirty1 <= 1'b0;
        r_dirty2 <= 1'b0;
      end

      if (bus.clr_scores) begin
        r_score1     <= '0;
        r_score2     <= '0;
        r_dirty1     <= 1'b1;
        r_dirty2     <= 1'b1;
        r_match_over <= 1'b0;
        r_winner     <= 1'b0;
        r_frame_cnt  <= 8'd0;
        r_serve_hold <= 1'b1;
        r_state      <= bus.enablePong ? SERVE : IDLE;
      end else if (!bus.enablePong) begin
        r_state      <= IDLE;
        r_serve_hold <= 1'b1;
        r_match_over <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state      <= SERVE;
            r_frame_cnt  <= 8'd0;
            r_serve_hold <= 1'b1;
          end
          SERVE: begin
            if (w_vs_fall) begin
              if (r_frame_cnt == LAST_FRAME) begin
                r_state      <= PLAY;
                r_frame_cnt  <= 8'd0;
                r_serve_hold <= 1'b0;
              end else begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
              end
            end
          end
          PLAY: begin
            if (w_goal1 && w_goal2) begin
              // Simultaneous goals are ambiguous: re-serve without a point.
              r_state      <= SERVE;
              r_frame_cnt  <= 8'd0;
              r_serve_hold <= 1'b1;
            end else if (w_goal1) begin
              r_score1     <= w_new1;
              r_dirty1     <= 1'b1;
              r_frame_cnt  <= 8'd0;
              r_serve_hold <= 1'b1;
              if (w_win1) begin
                r_state      <= OVER;
                r_match_over <= 1'b1;
                r_winner     <= 1'b0;
              end else begin
                r_state <= SERVE;
              end
            end else if (w_goal2) begin
              r_score2     <= w_new2;
              r_dirty2     <= 1'b1;
              r_frame_cnt  <= 8'd0;
              r_serve_hold <= 1'b1;
              if (w_win2) begin
                r_state      <= OVER;
                r_match_over <= 1'b1;
                r_winner     <= 1'b1;
              end else begin
                r_state <= SERVE;
              end
            end
          end
          OVER: begin
            r_serve_hold <= 1'b1;
          end
          default: begin
            r_state      <= IDLE;
            r_serve_hold <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.result[SCORE1_MSB:SCORE1_LSB] = r_score1;
  assign bus.result[DIRTY1]                = r_dirty1;
  assign bus.result[SCORE2_MSB:SCORE2_LSB] = r_score2;
  assign bus.result[DIRTY2]                = r_dirty2;
  assign bus.serve_hold                    = r_serve_hold;
  assign bus.match_over                    = r_match_over;
  assign bus.winner                        = r_winner;
  assign bus.dbg_state                     = r_state;

endmodule
